// File: rtl/pi_step_controller.sv
// ---------------------------------------------------------------------------
// pi_step_controller
//
// Sequencer for the 5x5 lane-permutation datapath. On an accepted start it
// loads a line, seeds (i,j)=(3,3), then walks the permutation cycle. For each
// step it computes the next index, reduces it mod 5 by repeated +5, then
// reads, writes and updates. The walk ends when the datapath reports that
// the coordinates are back at (3,3).
//
// Handshake: start is sampled only in IDLE. Each accepted start produces
// exactly one finish/ok pulse, error exits included. busy is high from
// leaving IDLE until IDLE is re-entered. A start that arrives while busy is
// dropped, not queued.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           walk request (IDLE only)
//   sign            datapath iNextPosAdd5[4]; 1 = candidate index negative
//   done            datapath flag (iReg==3 && jReg==3); used only in TST
//   initLine .. ok  Moore control strobes to the datapath / memory block
//   ALUop, fbeq,
//   fb3j, enable    unused controls, tied low
//   busy, finish    top-level status
//   err             sticky limit-exceeded flag; cleared by rst or next start
//   dbg_state       current state encoding:
//                   0 IDLE 1 INIT 2 CALC 3 CHK 4 MOD 5 RD 6 WR 7 UPD
//                   8 TST 9 FIN
// ---------------------------------------------------------------------------
module pi_step_controller #(
  parameter int MAX_STEPS = 24,
  parameter int MOD_MAX   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sign,
  input  logic       done,
  output logic       initLine,
  output logic       firstread,
  output logic       IJen,
  output logic       IJregen,
  output logic       isArith,
  output logic       ldTillPositive,
  output logic       waitCalNexti,
  output logic       read,
  output logic       writeVal,
  output logic       writeMemReg,
  output logic       write,
  output logic       update,
  output logic       ok,
  output logic       ALUop,
  output logic       fbeq,
  output logic       fb3j,
  output logic       enable,
  output logic       busy,
  output logic       finish,
  output logic       err,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_INIT = 4'd1,
    S_CALC = 4'd2,
    S_CHK  = 4'd3,
    S_MOD  = 4'd4,
    S_RD   = 4'd5,
    S_WR   = 4'd6,
    S_UPD  = 4'd7,
    S_TST  = 4'd8,
    S_FIN  = 4'd9
  } state_t;

  localparam logic [4:0] STEP_LIM = 5'(MAX_STEPS);
  localparam logic [2:0] MOD_LIM  = 3'(MOD_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] step_cnt;
  logic [2:0] mod_cnt;

  // Limit checks fire before either counter can overflow.
  logic mod_ok;
  logic step_limit;
  assign mod_ok     = (mod_cnt < MOD_LIM);
  assign step_limit = (step_cnt == STEP_LIM);

  assign ALUop     = 1'b0;
  assign fbeq      = 1'b0;
  assign fb3j      = 1'b0;
  assign enable    = 1'b0;
  assign dbg_state = state;

  // Next-state logic. done is deliberately looked at only in TST: right
  // after INIT the seed is (3,3), so done is already high and must not end
  // the walk.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_INIT;
      S_INIT: state_nxt = S_CALC;
      S_CALC: state_nxt = S_CHK;
      S_CHK: begin
        if (!sign)       state_nxt = S_RD;
        else if (mod_ok) state_nxt = S_MOD;
        else             state_nxt = S_FIN;
      end
      S_MOD:  state_nxt = S_CHK;
      S_RD:   state_nxt = S_WR;
      S_WR:   state_nxt = S_UPD;
      S_UPD:  state_nxt = S_TST;
      S_TST: begin
        if (done || step_limit) state_nxt = S_FIN;
        else                    state_nxt = S_CALC;
      end
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters, sticky error and registered Moore outputs. Outputs are
  // decoded from the state being entered so they line up with the state
  // register cycle for cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      step_cnt       <= '0;
      mod_cnt        <= '0;
      err            <= 1'b0;
      initLine       <= 1'b0;
      firstread      <= 1'b0;
      IJen           <= 1'b0;
      IJregen        <= 1'b0;
      isArith        <= 1'b0;
      ldTillPositive <= 1'b0;
      waitCalNexti   <= 1'b0;
      read           <= 1'b0;
      writeVal       <= 1'b0;
      writeMemReg    <= 1'b0;
      write          <= 1'b0;
      update         <= 1'b0;
      ok             <= 1'b0;
      finish         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state <= state_nxt;

      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            step_cnt <= '0;
            mod_cnt  <= '0;
          end
        end
        S_CALC: mod_cnt  <= '0;
        S_MOD:  mod_cnt  <= mod_cnt + 3'd1;
        S_UPD:  step_cnt <= step_cnt + 5'd1;
        S_CHK:  if (sign && !mod_ok) err <= 1'b1;
        S_TST:  if (!done && step_limit) err <= 1'b1;
        default: ;
      endcase

      initLine       <= 1'b0;
      firstread      <= 1'b0;
      IJen           <= 1'b0;
      IJregen        <= 1'b0;
      isArith        <= 1'b0;
      ldTillPositive <= 1'b0;
      waitCalNexti   <= 1'b0;
      read           <= 1'b0;
      writeVal       <= 1'b0;
      writeMemReg    <= 1'b0;
      write          <= 1'b0;
      update         <= 1'b0;
      ok             <= 1'b0;
      finish         <= 1'b0;
      busy           <= (state_nxt != S_IDLE);

      case (state_nxt)
        S_INIT: begin
          initLine  <= 1'b1;
          firstread <= 1'b1;
          IJen      <= 1'b1;
          IJregen   <= 1'b1;
        end
        S_CALC: begin
          // waitCalNexti stays low: the accumulator takes j - 3i directly.
          isArith        <= 1'b1;
          ldTillPositive <= 1'b1;
        end
        S_MOD: begin
          waitCalNexti   <= 1'b1;
          ldTillPositive <= 1'b1;
        end
        S_RD: begin
          read        <= 1'b1;
          writeVal    <= 1'b1;
          writeMemReg <= 1'b1;
        end
        S_WR:  write <= 1'b1;
        S_UPD: begin
          update  <= 1'b1;
          IJregen <= 1'b1;
        end
        S_FIN: begin
          ok     <= 1'b1;
          finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_step_controller.sv
// ---------------------------------------------------------------------------
// tb_pi_step_controller
//
// Directed bench. Each driven cycle names the state the controller should be
// in for that cycle plus the expected err level; the full expected output
// word is built from a hand-written per-state strobe table and queued. A
// monitor on the falling edge pops one word per cycle and compares it with
// the packed DUT outputs.
//
// Expected word layout (24 bits):
//   [23:20] state  [19] busy  [18] err
//   [17:4]  initLine firstread IJen IJregen isArith ldTillPositive
//           waitCalNexti read writeVal writeMemReg write update ok finish
//   [3:0]   ALUop fbeq fb3j enable
// ---------------------------------------------------------------------------
module tb_pi_step_controller;

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] INIT = 4'd1;
  localparam logic [3:0] CALC = 4'd2;
  localparam logic [3:0] CHK  = 4'd3;
  localparam logic [3:0] MOD  = 4'd4;
  localparam logic [3:0] RD   = 4'd5;
  localparam logic [3:0] WR   = 4'd6;
  localparam logic [3:0] UPD  = 4'd7;
  localparam logic [3:0] TST  = 4'd8;
  localparam logic [3:0] FIN  = 4'd9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sign = 1'b0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  logic initLine, firstread, IJen, IJregen, isArith, ldTillPositive;
  logic waitCalNexti, read, writeVal, writeMemReg, write, update, ok;
  logic ALUop, fbeq, fb3j, enable, busy, finish, err;
  logic [3:0] dbg_state;

  pi_step_controller #(.MAX_STEPS(24), .MOD_MAX(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .done(done),
    .initLine(initLine), .firstread(firstread), .IJen(IJen),
    .IJregen(IJregen), .isArith(isArith), .ldTillPositive(ldTillPositive),
    .waitCalNexti(waitCalNexti), .read(read), .writeVal(writeVal),
    .writeMemReg(writeMemReg), .write(write), .update(update), .ok(ok),
    .ALUop(ALUop), .fbeq(fbeq), .fb3j(fb3j), .enable(enable),
    .busy(busy), .finish(finish), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          tag_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;

  function automatic logic [23:0] exp_word(input logic [3:0] st, input logic e);
    logic [13:0] c;
    c = '0;
    case (st)
      INIT: c = 14'b11110000000000;
      CALC: c = 14'b00001100000000;
      MOD:  c = 14'b00000110000000;
      RD:   c = 14'b00000001110000;
      WR:   c = 14'b00000000001000;
      UPD:  c = 14'b00010000000100;
      FIN:  c = 14'b00000000000011;
      default: c = '0;
    endcase
    return {st, (st != IDLE), e, c, 4'b0000};
  endfunction

  // ---------------- driver tasks ----------------
  // Queue the expectation for the cycle just started and drive the inputs
  // that the controller will sample at the end of this cycle.
  task automatic cyc(input logic [3:0] st, input logic e, input logic s,
                     input logic d, input logic go, input logic r);
    @(posedge clk);
    #1;
    cyc_n++;
    exp_q.push_back(exp_word(st, e));
    tag_q.push_back(cyc_n);
    sign  = s;
    done  = d;
    start = go;
    rst   = r;
  endtask

  // One permutation step without reduction; done driven only in TST.
  task automatic plain_step(input logic d_tst);
    cyc(CALC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(CHK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(RD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(WR,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(UPD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(TST,  1'b0, 1'b0, d_tst, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [23:0] got;
    logic [23:0] want;
    int          tag;
    if (exp_q.size() > 0) begin
      got = {dbg_state, busy, err,
             initLine, firstread, IJen, IJregen, isArith, ldTillPositive,
             waitCalNexti, read, writeVal, writeMemReg, write, update, ok, finish,
             ALUop, fbeq, fb3j, enable};
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_%0d: got %h expected %h", tag, got, want);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single step, no reduction: INIT at 1, FIN at 8, IDLE at 9.
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    plain_step(1'b1);
    cyc(FIN,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reduction loop: two MOD passes, 10-cycle step.
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(CALC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(CHK,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(MOD,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(CHK,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(MOD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(CHK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(RD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(WR,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(UPD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(TST,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(FIN,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Seed done ignored, start held high while busy and through FIN:
    // exit only at TST, then one IDLE cycle and a re-trigger.
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(INIT, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(CALC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(CHK,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(RD,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(WR,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(UPD,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(TST,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(FIN,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-walk, asserted during WR.
    cyc(CALC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(CHK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(RD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(WR,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Step limit: 24 steps with done low, then err and finish.
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) plain_step(1'b0);
    cyc(FIN,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reduction limit: sign stuck high -> 4 MOD passes, err, no RD/WR.
    // The new start also clears the err left by the step-limit run.
    cyc(IDLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(CALC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(CHK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(MOD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cyc(CHK,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(FIN,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(IDLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Next start clears err; a clean one-step walk follows.
    cyc(INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    plain_step(1'b1);
    cyc(FIN,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drain: the monitor must have consumed every expectation.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
